fwrisc_ldst_unit: RTL and testbench
===================================

# fwrisc_ldst_unit

Load/store execution unit for the FWRISC core. It accepts one decoded memory operation at a time from the decode/exec boundary and computes the effective address. It then performs a single data-bus transaction with byte-lane steering, and returns sign- or zero-extended load data as a register write-back. It sits between the exec stage's operand bus (`op_a`/`op_b`/`op_c`/`op`/`rd`) and the core's data port (`dvalid`/`dready`).

## Interface
No parameters.
- clock  in  1  clock; all logic on posedge
- reset  in  1  reset, synchronous, active-high
- req_valid  in  1  memory op present; held by decode until `complete`
- op  in  4  mem op: LB=0, LH=1, LW=2, LBU=3, LHU=4, SB=5, SH=6, SW=7; 8..15 illegal
- op_a  in  32  base address
- op_c  in  32  sign-extended offset
- op_b  in  32  store data
- rd  in  6  destination register
- complete  out  1  one-cycle pulse: operation finished
- misalign  out  1  valid with `complete`: access not naturally aligned, no bus access made
- rd_wen  out  1  valid with `complete`: write `rd_wdata` to `rd_waddr`
- rd_waddr  out  6  latched `rd`
- rd_wdata  out  32  extended load data
- daddr  out  32  word address, `{ea[31:2],2'b00}`
- dvalid  out  1  bus request
- dwrite  out  1  1 = store
- dwstb  out  4  byte write strobes (0 for loads)
- dwdata  out  32  lane-replicated store data
- drdata  in  32  read data, valid while `dready`=1
- dready  in  1  transaction accept/return

## Operation
- Effective address `ea = op_a + op_c`, modulo 2^32; wrap from 0xFFFFFFFF to 0 is legal.
- States: IDLE, BUS, DONE.
- IDLE:
  - `req_valid`=1 samples `op`, `op_b`, `rd` and `ea` into registers.
  - Aligned legal op → BUS.
  - Misaligned op (LH/LHU/SH with `ea[0]`=1; LW/SW with `ea[1:0]`≠0) or illegal op → DONE with no bus access.
- BUS: `dvalid`=1 with `daddr`, `dwrite`, `dwstb` and `dwdata` stable. The edge that samples `dready`=1 captures `drdata` and moves to DONE.
- DONE: `complete`=1 for one cycle, then → IDLE.
- Store lanes:
  - SB: `dwdata={4{op_b[7:0]}}`, `dwstb=4'b0001<<ea[1:0]`.
  - SH: `dwdata={2{op_b[15:0]}}`, `dwstb=4'b0011<<ea[1:0]`.
  - SW: `dwdata=op_b`, `dwstb=4'b1111`.
- Load extract: `v = drdata >> (8*ea[1:0])`.
  - LB sign-extends `v[7:0]`; LBU zero-extends it.
  - LH/LHU sign- or zero-extend `v[15:0]`.
  - LW uses `drdata`.
- `rd_wen`=1 only in DONE for a completed aligned load with `rd`≠0. It is 0 for stores, misaligned ops, illegal ops, and `rd`=0.
- `misalign`=1 in DONE only for the misaligned case; illegal ops complete with `misalign`=0 and no write.
- `req_valid` is ignored outside IDLE.

## Timing
- Reset values: state IDLE; `complete`, `misalign`, `rd_wen`, `dvalid`, `dwrite` = 0; `dwstb`=0; `daddr`, `dwdata`, `rd_waddr`, `rd_wdata` = 0.
- Request accepted at edge N:
  - `dvalid`=1 from N+1.
  - If `dready`=1 is sampled at edge M, `dvalid`=0 and `complete`=1 from M+1, and the unit is IDLE from M+2.
  - Minimum latency with `dready` sampled at edge N+1: `complete` in cycle N+2.
- Misaligned or illegal op accepted at edge N: `complete`=1 in cycle N+1 and `dvalid` never asserts.
- `dvalid` deasserts on the same edge that samples `dready`. A responder that holds `dready` for a single cycle therefore never sees a second request.
- `dready`=1 while not in BUS is ignored.
- Back-to-back ops: decode drops `req_valid` while `complete`=1. A new request can be accepted at the edge ending the IDLE cycle that follows DONE.
- `reset` asserted in any state returns the unit to IDLE with all outputs at reset values on the next edge. An in-flight bus request is abandoned with no `complete`.

## Test plan
- LW, `op_a`=0x1000, `op_c`=4, `rd`=5, memory returns 0xDEADBEEF one cycle after `dvalid` → `daddr`=0x1004, `dwstb`=0, `complete` with `rd_wen`=1, `rd_waddr`=5, `rd_wdata`=0xDEADBEEF, 3 cycles after accept.
- LB, `ea`=0x2003, `drdata`=0x80FFFFFF → `rd_wdata`=0xFFFFFF80. Same access with LBU → `rd_wdata`=0x00000080.
- SH, `ea`=0x3002, `op_b`=0x1234ABCD → `dwrite`=1, `dwstb`=4'b1100, `dwdata`=0xABCDABCD, `rd_wen`=0.
- LW with `ea`=0x4001 → `complete` and `misalign`=1 in the cycle after accept, `dvalid` stays 0, `rd_wen`=0.
- Address wrap: `op_a`=0xFFFFFFFC, `op_c`=8, SB with `op_b`=0x5A → `daddr`=0x4, `dwstb`=4'b0001, `dwdata`=0x5A5A5A5A. LB with `rd`=0 → `rd_wen`=0.
- `reset` asserted while `dvalid`=1 and `dready` withheld → next cycle `dvalid`=0, no `complete`. A following LW completes normally.

Source files
------------

// File: rtl/fwrisc_ldst_unit.sv
// FWRISC load/store unit: effective-address generation, one data-bus transaction
// with byte-lane steering, and sign/zero-extended load write-back.
module fwrisc_ldst_unit (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    input  logic [3:0]  op,
    input  logic [31:0] op_a,
    input  logic [31:0] op_c,
    input  logic [31:0] op_b,
    input  logic [5:0]  rd,
    output logic        complete,
    output logic        misalign,
    output logic        rd_wen,
    output logic [5:0]  rd_waddr,
    output logic [31:0] rd_wdata,
    output logic [31:0] daddr,
    output logic        dvalid,
    output logic        dwrite,
    output logic [3:0]  dwstb,
    output logic [31:0] dwdata,
    input  logic [31:0] drdata,
    input  logic        dready,
    output logic [1:0]  state_dbg
);

    localparam logic [3:0] OP_LB  = 4'd0;
    localparam logic [3:0] OP_LH  = 4'd1;
    localparam logic [3:0] OP_LW  = 4'd2;
    localparam logic [3:0] OP_LBU = 4'd3;
    localparam logic [3:0] OP_LHU = 4'd4;
    localparam logic [3:0] OP_SB  = 4'd5;
    localparam logic [3:0] OP_SH  = 4'd6;
    localparam logic [3:0] OP_SW  = 4'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [3:0]  op_q;
    logic [31:0] ea_q;
    logic [31:0] op_b_q;
    logic [5:0]  rd_q;
    logic        skip_q;
    logic        misal_q;

    logic [31:0] ea;
    logic        legal;
    logic        misal_in;
    logic [31:0] ld_shift;
    logic [31:0] ld_val;

    assign state_dbg = state;

    always_comb begin
        ea       = op_a + op_c;
        legal    = (op <= OP_SW);
        misal_in = 1'b0;
        if ((op == OP_LH || op == OP_LHU || op == OP_SH) && ea[0])
            misal_in = 1'b1;
        if ((op == OP_LW || op == OP_SW) && (ea[1:0] != 2'b00))
            misal_in = 1'b1;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (req_valid) state_nxt = (!legal || misal_in) ? DONE : BUS;
            BUS:  if (dready)    state_nxt = DONE;
            DONE:                state_nxt = IDLE;
            default:             state_nxt = IDLE;
        endcase
    end

    // Lane selection uses the byte offset inside the returned word.
    always_comb begin
        ld_shift = drdata >> {ea_q[1:0], 3'b000};
        ld_val   = drdata;
        case (op_q)
            OP_LB:   ld_val = {{24{ld_shift[7]}}, ld_shift[7:0]};
            OP_LBU:  ld_val = {24'd0, ld_shift[7:0]};
            OP_LH:   ld_val = {{16{ld_shift[15]}}, ld_shift[15:0]};
            OP_LHU:  ld_val = {16'd0, ld_shift[15:0]};
            default: ld_val = drdata;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            op_q     <= 4'd0;
            ea_q     <= 32'd0;
            op_b_q   <= 32'd0;
            rd_q     <= 6'd0;
            skip_q   <= 1'b0;
            misal_q  <= 1'b0;
            rd_wdata <= 32'd0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && req_valid) begin
                op_q    <= op;
                ea_q    <= ea;
                op_b_q  <= op_b;
                rd_q    <= rd;
                skip_q  <= !legal || misal_in;
                misal_q <= legal && misal_in;
            end
            if (state == BUS && dready)
                rd_wdata <= ld_val;
        end
    end

    // Bus handshake: dvalid stays high with stable address/data/strobes until the
    // edge that samples dready=1; that same edge drops dvalid.
    always_comb begin
        dvalid   = (state == BUS);
        dwrite   = dvalid && (op_q >= OP_SB) && (op_q <= OP_SW);
        daddr    = {ea_q[31:2], 2'b00};
        dwstb    = 4'b0000;
        dwdata   = op_b_q;
        case (op_q)
            OP_SB: dwdata = {4{op_b_q[7:0]}};
            OP_SH: dwdata = {2{op_b_q[15:0]}};
            default: dwdata = op_b_q;
        endcase
        if (dwrite) begin
            case (op_q)
                OP_SB:   dwstb = 4'b0001 << ea_q[1:0];
                OP_SH:   dwstb = 4'b0011 << ea_q[1:0];
                default: dwstb = 4'b1111;
            endcase
        end
        complete = (state == DONE);
        misalign = complete && misal_q;
        rd_wen   = complete && !skip_q && (op_q <= OP_LHU) && (rd_q != 6'd0);
        rd_waddr = rd_q;
    end

endmodule

// File: tb/tb_fwrisc_ldst_unit.sv
// Directed bench for fwrisc_ldst_unit: hand-computed vectors for loads, stores,
// misalignment, illegal ops, address wrap and mid-transaction reset.
module tb_fwrisc_ldst_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid;
    logic [3:0]  op;
    logic [31:0] op_a, op_c, op_b;
    logic [5:0]  rd;
    logic        complete, misalign, rd_wen;
    logic [5:0]  rd_waddr;
    logic [31:0] rd_wdata, daddr, dwdata, drdata;
    logic        dvalid, dwrite, dready;
    logic [3:0]  dwstb;
    logic [1:0]  state_dbg;

    int n_checks = 0;
    int n_fail   = 0;

    fwrisc_ldst_unit dut (
        .clock(clock), .reset(reset), .req_valid(req_valid), .op(op),
        .op_a(op_a), .op_c(op_c), .op_b(op_b), .rd(rd),
        .complete(complete), .misalign(misalign), .rd_wen(rd_wen),
        .rd_waddr(rd_waddr), .rd_wdata(rd_wdata), .daddr(daddr),
        .dvalid(dvalid), .dwrite(dwrite), .dwstb(dwstb), .dwdata(dwdata),
        .drdata(drdata), .dready(dready), .state_dbg(state_dbg)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Present a request in an IDLE cycle; returns #1 after the accepting edge.
    task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] c,
                         input logic [31:0] b, input logic [5:0] r);
        @(negedge clock);
        op = o; op_a = a; op_c = c; op_b = b; rd = r; req_valid = 1'b1;
        @(posedge clock);
        #1;
    endtask

    // Wait `stall` cycles in BUS, then return data; ends #1 after the sampling edge.
    task automatic respond(input logic [31:0] data, input int stall);
        for (int i = 0; i < stall; i++) begin
            @(negedge clock);
            dready = 1'b0;
            @(posedge clock);
            #1;
            check("dvalid_held", 32'(dvalid), 32'd1);
        end
        @(negedge clock);
        dready = 1'b1; drdata = data;
        @(posedge clock);
        #1;
        dready = 1'b0;
        check("dvalid_drop", 32'(dvalid), 32'd0);
        check("complete", 32'(complete), 32'd1);
    endtask

    // Called during the DONE cycle: drop the request and confirm return to IDLE.
    task automatic finish_op();
        @(negedge clock);
        req_valid = 1'b0;
        @(posedge clock);
        #1;
        check("complete_pulse", 32'(complete), 32'd0);
        check("idle", 32'(state_dbg), 32'd0);
    endtask

    initial begin
        reset = 1'b1; req_valid = 1'b0; op = 4'd0; op_a = 32'd0; op_c = 32'd0;
        op_b = 32'd0; rd = 6'd0; drdata = 32'd0; dready = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check("rst_complete", 32'(complete), 32'd0);
        check("rst_dvalid", 32'(dvalid), 32'd0);
        check("rst_dwstb", 32'(dwstb), 32'd0);
        check("rst_daddr", daddr, 32'd0);
        check("rst_rd_wdata", rd_wdata, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        // dready outside BUS must not move the unit
        dready = 1'b1;
        @(posedge clock);
        #1;
        dready = 1'b0;
        check("stray_dready", 32'(complete), 32'd0);

        // LW aligned, minimum latency
        issue(4'd2, 32'h1000, 32'd4, 32'd0, 6'd5);
        check("lw_dvalid", 32'(dvalid), 32'd1);
        check("lw_daddr", daddr, 32'h1004);
        check("lw_dwstb", 32'(dwstb), 32'd0);
        check("lw_dwrite", 32'(dwrite), 32'd0);
        respond(32'hDEADBEEF, 0);
        check("lw_rd_wen", 32'(rd_wen), 32'd1);
        check("lw_rd_waddr", 32'(rd_waddr), 32'd5);
        check("lw_rd_wdata", rd_wdata, 32'hDEADBEEF);
        check("lw_misalign", 32'(misalign), 32'd0);
        finish_op();

        // LB / LBU on top byte lane
        issue(4'd0, 32'h2000, 32'd3, 32'd0, 6'd7);
        check("lb_daddr", daddr, 32'h2000);
        respond(32'h80FFFFFF, 2);
        check("lb_rd_wdata", rd_wdata, 32'hFFFFFF80);
        check("lb_rd_wen", 32'(rd_wen), 32'd1);
        finish_op();
        issue(4'd3, 32'h2000, 32'd3, 32'd0, 6'd7);
        respond(32'h80FFFFFF, 0);
        check("lbu_rd_wdata", rd_wdata, 32'h00000080);
        finish_op();

        // LH / LHU on upper half
        issue(4'd1, 32'h2000, 32'd2, 32'd0, 6'd9);
        respond(32'h80011234, 0);
        check("lh_rd_wdata", rd_wdata, 32'hFFFF8001);
        finish_op();
        issue(4'd4, 32'h2000, 32'd2, 32'd0, 6'd9);
        respond(32'h80011234, 1);
        check("lhu_rd_wdata", rd_wdata, 32'h00008001);
        finish_op();

        // SH upper half
        issue(4'd6, 32'h3000, 32'd2, 32'h1234ABCD, 6'd3);
        check("sh_dwrite", 32'(dwrite), 32'd1);
        check("sh_dwstb", 32'(dwstb), 32'hC);
        check("sh_dwdata", dwdata, 32'hABCDABCD);
        check("sh_daddr", daddr, 32'h3000);
        respond(32'd0, 1);
        check("sh_rd_wen", 32'(rd_wen), 32'd0);
        finish_op();

        // SW aligned
        issue(4'd7, 32'h5000, 32'hFFFFFFFC, 32'hCAFEF00D, 6'd1);
        check("sw_daddr", daddr, 32'h4FFC);
        check("sw_dwstb", 32'(dwstb), 32'hF);
        check("sw_dwdata", dwdata, 32'hCAFEF00D);
        respond(32'd0, 0);
        check("sw_rd_wen", 32'(rd_wen), 32'd0);
        finish_op();

        // Misaligned LW: completes next cycle, no bus
        issue(4'd2, 32'h4000, 32'd1, 32'd0, 6'd4);
        check("mis_complete", 32'(complete), 32'd1);
        check("mis_misalign", 32'(misalign), 32'd1);
        check("mis_dvalid", 32'(dvalid), 32'd0);
        check("mis_rd_wen", 32'(rd_wen), 32'd0);
        finish_op();

        // Misaligned SH on odd address
        issue(4'd6, 32'h4000, 32'd3, 32'h1, 6'd0);
        check("missh_misalign", 32'(misalign), 32'd1);
        check("missh_dvalid", 32'(dvalid), 32'd0);
        finish_op();

        // Illegal op
        issue(4'd9, 32'h4000, 32'd0, 32'd0, 6'd4);
        check("ill_complete", 32'(complete), 32'd1);
        check("ill_misalign", 32'(misalign), 32'd0);
        check("ill_rd_wen", 32'(rd_wen), 32'd0);
        check("ill_dvalid", 32'(dvalid), 32'd0);
        finish_op();

        // Address wrap with SB, then LB to x0
        issue(4'd5, 32'hFFFFFFFC, 32'd8, 32'h5A, 6'd2);
        check("wrap_daddr", daddr, 32'h4);
        check("wrap_dwstb", 32'(dwstb), 32'h1);
        check("wrap_dwdata", dwdata, 32'h5A5A5A5A);
        respond(32'd0, 0);
        finish_op();
        issue(4'd0, 32'hFFFFFFFC, 32'd8, 32'd0, 6'd0);
        respond(32'h000000FF, 0);
        check("x0_rd_wen", 32'(rd_wen), 32'd0);
        finish_op();

        // Reset mid-transaction abandons the request
        issue(4'd2, 32'h6000, 32'd0, 32'd0, 6'd8);
        check("rstbus_dvalid", 32'(dvalid), 32'd1);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        check("rstbus_dvalid_drop", 32'(dvalid), 32'd0);
        check("rstbus_complete", 32'(complete), 32'd0);
        @(negedge clock);
        reset = 1'b0; req_valid = 1'b0;
        @(posedge clock);
        #1;
        check("rstbus_no_complete", 32'(complete), 32'd0);
        issue(4'd2, 32'h6000, 32'd8, 32'd0, 6'd10);
        check("post_daddr", daddr, 32'h6008);
        respond(32'h13579BDF, 0);
        check("post_rd_wdata", rd_wdata, 32'h13579BDF);
        check("post_rd_waddr", 32'(rd_waddr), 32'd10);
        check("post_rd_wen", 32'(rd_wen), 32'd1);
        finish_op();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
